row_receiver: RTL

ROW_RECEIVER -- requirements
Module: row_receiver

---
 rtl/row_receiver.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/row_receiver.sv
// Receives image rows word by word (requesting each row from the host) or a
// stream of CNN data words, and issues write strobes for the downstream memories.
module row_receiver #(
  parameter int WORD_W        = 16,
  parameter int WORDS_PER_ROW = 30,
  parameter int NUM_ROWS      = 30,
  parameter int NUM_WEIGHTS   = 400,
  parameter int ROW_AW        = 5,
  parameter int WGT_AW        = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_process,
  input  logic                            cnn_image,
  input  logic                            stop,
  input  logic [WORD_W-1:0]               data_in,
  input  logic                            data_valid,
  output logic                            send,
  output logic [WORD_W*WORDS_PER_ROW-1:0] row_out,
  output logic [ROW_AW-1:0]               row_addr,
  output logic                            row_we,
  output logic [WORD_W-1:0]               wgt_data,
  output logic [WGT_AW-1:0]               wgt_addr,
  output logic                            wgt_we,
  output logic                            busy,
  output logic                            done
);

  localparam int ROW_W = WORD_W * WORDS_PER_ROW;
  localparam int WC_W  = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_RECV  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [WC_W-1:0]   wordCnt_q, wordCnt_d;
  logic [ROW_AW-1:0] rowCnt_q, rowCnt_d;
  logic [WGT_AW-1:0] wgtCnt_q, wgtCnt_d;
  logic [ROW_W-1:0]  row_q;
  logic [WORD_W-1:0] wgtData_q;
  logic [WGT_AW-1:0] wgtAddr_q;
  logic              send_q, rowWe_q, wgtWe_q, busy_q, done_q;
  logic              accept;
  logic              lastWord, lastRow, lastWgt;

  assign lastWord = (wordCnt_q == WC_W'(WORDS_PER_ROW - 1));
  assign lastRow  = (rowCnt_q == ROW_AW'(NUM_ROWS - 1));
  assign lastWgt  = (wgtCnt_q == WGT_AW'(NUM_WEIGHTS - 1));

  // Stop wins over data and row completion; counters saturate at their last index.
  always_comb begin
    state_d   = state_q;
    wordCnt_d = wordCnt_q;
    rowCnt_d  = rowCnt_q;
    wgtCnt_d  = wgtCnt_q;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_process) begin
          if (cnn_image) begin
            state_d  = S_DATA;
            wgtCnt_d = '0;
          end else begin
            state_d  = S_REQ;
            rowCnt_d = '0;
          end
        end
      end
      S_REQ: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          wordCnt_d = '0;
          state_d   = S_RECV;
        end
      end
      S_RECV: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (data_valid) begin
          accept = 1'b1;
          if (lastWord) begin
            state_d = S_WRITE;
          end else begin
            wordCnt_d = wordCnt_q + WC_W'(1);
          end
        end
      end
      S_WRITE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (lastRow) begin
          state_d = S_DONE;
        end else begin
          rowCnt_d = rowCnt_q + ROW_AW'(1);
          state_d  = S_REQ;
        end
      end
      S_DATA: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (data_valid) begin
          accept = 1'b1;
          if (lastWgt) begin
            state_d = S_DONE;
          end else begin
            wgtCnt_d = wgtCnt_q + WGT_AW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each is high for exactly
  // the one cycle spent in its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wordCnt_q <= '0;
      rowCnt_q  <= '0;
      wgtCnt_q  <= '0;
      row_q     <= '0;
      wgtData_q <= '0;
      wgtAddr_q <= '0;
      send_q    <= 1'b0;
      rowWe_q   <= 1'b0;
      wgtWe_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wordCnt_q <= wordCnt_d;
      rowCnt_q  <= rowCnt_d;
      wgtCnt_q  <= wgtCnt_d;
      send_q    <= (state_d == S_REQ);
      rowWe_q   <= (state_d == S_WRITE);
      done_q    <= (state_d == S_DONE);
      busy_q    <= (state_d != S_IDLE);
      wgtWe_q   <= accept && (state_q == S_DATA);
      if (accept && (state_q == S_DATA)) begin
        wgtData_q <= data_in;
        wgtAddr_q <= wgtCnt_q;
      end
      if (accept && (state_q == S_RECV)) begin
        for (int k = 0; k < WORDS_PER_ROW; k++) begin
          if (wordCnt_q == WC_W'(k)) begin
            row_q[k*WORD_W +: WORD_W] <= data_in;
          end
        end
      end
    end
  end

  assign send     = send_q;
  assign row_out  = row_q;
  assign row_addr = rowCnt_q;
  assign row_we   = rowWe_q;
  assign wgt_data = wgtData_q;
  assign wgt_addr = wgtAddr_q;
  assign wgt_we   = wgtWe_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
